// File: rtl/histogram_esitleme_p_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : he_paket (package)
//  Description : Shared definitions for the histogram equalisation engine:
//                state encoding and derivations of BINS and the numerator
//                width from the pixel and count widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package he_paket;

    localparam logic [2:0] C_DURUM_IDLE  = 3'd0;
    localparam logic [2:0] C_DURUM_CLEAR = 3'd1;
    localparam logic [2:0] C_DURUM_ACCUM = 3'd2;
    localparam logic [2:0] C_DURUM_CDF   = 3'd3;
    localparam logic [2:0] C_DURUM_LUT   = 3'd4;
    localparam logic [2:0] C_DURUM_MAP   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = C_DURUM_IDLE,
        S_CLEAR = C_DURUM_CLEAR,
        S_ACCUM = C_DURUM_ACCUM,
        S_CDF   = C_DURUM_CDF,
        S_LUT   = C_DURUM_LUT,
        S_MAP   = C_DURUM_MAP
    } durum_t;

    // Number of histogram bins for a given pixel width.
    function automatic int bins_of(input int pixel_bit);
        return 1 << pixel_bit;
    endfunction

    // Width of the LUT numerator: a CDF difference times (BINS-1).
    function automatic int num_w_of(input int count_bit, input int pixel_bit);
        return count_bit + pixel_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/histogram_esitleme_p_if.sv
`default_nettype none
// ============================================================================
//  Module      : histogram_esitleme_p_if
//  Description : Pixel stream bundle. The source (master) drives the input
//                pixel, valid and last-pixel flag and observes ready and the
//                mapped pixel stream; the engine is the slave.
//                Signals: pixel_valid_i, pixel_i, son_i, pixel_ready_o,
//                pixel_valid_o, pixel_o.
//  Revision    : 1.0 - initial release
// ============================================================================
interface histogram_esitleme_p_if #(
    parameter int PIXEL_BIT = 8
);
    logic                 pixel_valid_i;
    logic [PIXEL_BIT-1:0] pixel_i;
    logic                 son_i;
    logic                 pixel_ready_o;
    logic                 pixel_valid_o;
    logic [PIXEL_BIT-1:0] pixel_o;

    modport master (
        output pixel_valid_i, pixel_i, son_i,
        input  pixel_ready_o, pixel_valid_o, pixel_o
    );

    modport slave (
        input  pixel_valid_i, pixel_i, son_i,
        output pixel_ready_o, pixel_valid_o, pixel_o
    );
endinterface
`default_nettype wire

// File: rtl/histogram_esitleme_p_bolucu.sv
`default_nettype none
// ============================================================================
//  Module      : he_bolucu
//  Description : Unsigned restoring divider, one quotient bit per cycle.
//                baslat loads the operands; gecerli pulses for one cycle
//                with bolum valid W+1 cycles after the launch (launch cycle
//                included). A new baslat restarts the divide.
//  Ports       : clk_i, rst_i, baslat, bolunen[W], bolen[W] -> bolum[W], gecerli
//  Revision    : 1.0 - initial release
// ============================================================================
module he_bolucu #(
    parameter int W = 25
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    input  wire logic         baslat,
    input  wire logic [W-1:0] bolunen,
    input  wire logic [W-1:0] bolen,
    output logic      [W-1:0] bolum,
    output logic              gecerli
);
    localparam int SW = $clog2(W + 1);

    logic [W-1:0]  r_kalan;
    logic [W-1:0]  r_q;       // dividend shifts out the top, quotient bits in the bottom
    logic [W-1:0]  r_bolen;
    logic [SW-1:0] r_sayac;
    logic          r_mesgul;
    logic          r_gecerli;

    logic [W:0]    w_kaydir;
    logic [W-1:0]  w_kalan_yeni;
    logic          w_bit;

    // The partial remainder is always below the divisor, so the shifted
    // trial value fits in W+1 bits and the restored remainder in W bits.
    always_comb begin
        w_kaydir     = {r_kalan, r_q[W-1]};
        w_bit        = (w_kaydir >= {1'b0, r_bolen});
        w_kalan_yeni = w_bit ? W'(w_kaydir - {1'b0, r_bolen}) : w_kaydir[W-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_kalan   <= '0;
            r_q       <= '0;
            r_bolen   <= '0;
            r_sayac   <= '0;
            r_mesgul  <= 1'b0;
            r_gecerli <= 1'b0;
        end else begin
            r_gecerli <= 1'b0;
            if (baslat) begin
                r_kalan  <= '0;
                r_q      <= bolunen;
                r_bolen  <= bolen;
                r_sayac  <= SW'(W);
                r_mesgul <= 1'b1;
            end else if (r_mesgul) begin
                r_kalan <= w_kalan_yeni;
                r_q     <= {r_q[W-2:0], w_bit};
                r_sayac <= r_sayac - 1'b1;
                if (r_sayac == SW'(1)) begin
                    r_mesgul  <= 1'b0;
                    r_gecerli <= 1'b1;
                end
            end
        end
    end

    assign bolum   = r_q;
    assign gecerli = r_gecerli;

endmodule
`default_nettype wire

// File: rtl/histogram_esitleme_p.sv
`default_nettype none
// ============================================================================
//  Module      : histogram_esitleme_p
//  Description : Full-frame histogram equalisation engine. Per frame:
//                CLEAR bins, ACCUM histogram, CDF in place, LUT build with
//                an iterative divider, then MAP pixels through the LUT.
//                Optional macro HE_CLIP_EN clips each bin to CLIP_LIMIT in
//                the CDF pass and replaces toplam_o with the clipped sum.
//  Ports       : clk_i, rst_i, baslat_i, bus (pixel stream, slave),
//                hazir_o, cdf_min_o, toplam_o, tasma_o, durum_o
//  Revision    : 1.0 - initial release
// ============================================================================
module histogram_esitleme_p
    import he_paket::*;
#(
    parameter int PIXEL_BIT  = 8,
    parameter int COUNT_BIT  = 17,
    parameter int CLIP_LIMIT = 1024
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    input  wire logic                 baslat_i,
    histogram_esitleme_p_if.slave     bus,
    output logic                      hazir_o,
    output logic      [COUNT_BIT-1:0] cdf_min_o,
    output logic      [COUNT_BIT-1:0] toplam_o,
    output logic                      tasma_o,
    output logic      [2:0]           durum_o
);
    localparam int BINS  = bins_of(PIXEL_BIT);
    localparam int NUM_W = num_w_of(COUNT_BIT, PIXEL_BIT);
    localparam logic [COUNT_BIT-1:0] C_TOPLAM_MAX = '1;

    durum_t               r_durum, w_durum_sonraki;
    logic [COUNT_BIT-1:0] r_bins [BINS];
    logic [PIXEL_BIT-1:0] r_lut  [BINS];
    logic [PIXEL_BIT-1:0] r_idx;
    logic [COUNT_BIT-1:0] r_acc, r_toplam, r_cdf_min;
    logic                 r_min_bulundu, r_bekle, r_tasma, r_hazir;
    logic                 r_pv_o;
    logic [PIXEL_BIT-1:0] r_pix_o;

    logic                 w_ready, w_kabul, w_son_kabul, w_idx_son;
    logic [COUNT_BIT-1:0] w_bin_eff, w_acc_yeni, w_fark, w_payda;
    logic [NUM_W-1:0]     w_pay, w_bolum;
    logic                 w_div_baslat, w_div_gecerli, w_lut_adim;
    logic [PIXEL_BIT-1:0] w_lut_deger;

    always_comb begin
        w_ready     = (r_durum == S_ACCUM) || (r_durum == S_MAP);
        w_kabul     = bus.pixel_valid_i && w_ready;
        w_son_kabul = w_kabul && bus.son_i;
        w_idx_son   = (r_idx == '1);
`ifdef HE_CLIP_EN
        w_bin_eff   = (32'(r_bins[r_idx]) > CLIP_LIMIT) ? COUNT_BIT'(CLIP_LIMIT) : r_bins[r_idx];
`else
        w_bin_eff   = r_bins[r_idx];
`endif
        w_acc_yeni  = r_acc + w_bin_eff;
        w_fark      = (r_bins[r_idx] >= r_cdf_min) ? (r_bins[r_idx] - r_cdf_min) : '0;
        w_pay       = NUM_W'(w_fark) * NUM_W'(BINS - 1);
        // toplam never falls below any CDF value, so this cannot underflow.
        w_payda     = r_toplam - r_cdf_min;
        // A zero denominator skips the divider and stores the identity.
        w_div_baslat = (r_durum == S_LUT) && !r_bekle && (w_payda != '0);
        w_lut_adim   = (r_durum == S_LUT) && (r_bekle ? w_div_gecerli : (w_payda == '0));
        w_lut_deger  = (w_bolum > NUM_W'(BINS - 1)) ? '1 : w_bolum[PIXEL_BIT-1:0];
    end

    he_bolucu #(.W(NUM_W)) u_bolucu (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .baslat  (w_div_baslat),
        .bolunen (w_pay),
        .bolen   (NUM_W'(w_payda)),
        .bolum   (w_bolum),
        .gecerli (w_div_gecerli)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_durum <= S_IDLE;
        else       r_durum <= w_durum_sonraki;
    end

    always_comb begin
        w_durum_sonraki = r_durum;
        case (r_durum)
            S_IDLE:  if (baslat_i)                w_durum_sonraki = S_CLEAR;
            S_CLEAR: if (w_idx_son)               w_durum_sonraki = S_ACCUM;
            S_ACCUM: if (w_son_kabul)             w_durum_sonraki = S_CDF;
            S_CDF:   if (w_idx_son)               w_durum_sonraki = S_LUT;
            S_LUT:   if (w_lut_adim && w_idx_son) w_durum_sonraki = S_MAP;
            S_MAP:   if (w_son_kabul)             w_durum_sonraki = S_IDLE;
            default:                              w_durum_sonraki = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < BINS; b++) begin
                r_bins[b] <= '0;
                r_lut[b]  <= '0;
            end
            r_idx         <= '0;
            r_acc         <= '0;
            r_toplam      <= '0;
            r_cdf_min     <= '0;
            r_min_bulundu <= 1'b0;
            r_bekle       <= 1'b0;
            r_tasma       <= 1'b0;
            r_hazir       <= 1'b0;
            r_pv_o        <= 1'b0;
            r_pix_o       <= '0;
        end else begin
            r_hazir <= 1'b0;
            r_pv_o  <= 1'b0;
            case (r_durum)
                S_IDLE: begin
                    if (baslat_i) begin
                        r_tasma   <= 1'b0;
                        r_toplam  <= '0;
                        r_cdf_min <= '0;
                        r_idx     <= '0;
                    end
                end
                S_CLEAR: begin
                    // r_idx wraps back to 0 on the last bin, ready for CDF.
                    r_bins[r_idx] <= '0;
                    r_idx         <= r_idx + 1'b1;
                    r_acc         <= '0;
                    r_min_bulundu <= 1'b0;
                end
                S_ACCUM: begin
                    if (w_kabul) begin
                        if (r_toplam == C_TOPLAM_MAX) begin
                            r_tasma <= 1'b1;
                        end else begin
                            r_bins[bus.pixel_i] <= r_bins[bus.pixel_i] + 1'b1;
                            r_toplam            <= r_toplam + 1'b1;
                        end
                    end
                end
                S_CDF: begin
                    r_bins[r_idx] <= w_acc_yeni;
                    r_acc         <= w_acc_yeni;
                    r_idx         <= r_idx + 1'b1;
                    r_bekle       <= 1'b0;
                    if (!r_min_bulundu && (w_acc_yeni != '0)) begin
                        r_cdf_min     <= w_acc_yeni;
                        r_min_bulundu <= 1'b1;
                    end
`ifdef HE_CLIP_EN
                    if (w_idx_son) r_toplam <= w_acc_yeni;
`endif
                end
                S_LUT: begin
                    if (w_div_baslat) r_bekle <= 1'b1;
                    if (w_lut_adim) begin
                        r_lut[r_idx] <= r_bekle ? w_lut_deger : r_idx;
                        r_bekle      <= 1'b0;
                        r_idx        <= r_idx + 1'b1;
                        if (w_idx_son) r_hazir <= 1'b1;
                    end
                end
                S_MAP: begin
                    if (w_kabul) begin
                        r_pv_o  <= 1'b1;
                        r_pix_o <= r_lut[bus.pixel_i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pixel_ready_o = w_ready;
    assign bus.pixel_valid_o = r_pv_o;
    assign bus.pixel_o       = r_pix_o;
    assign hazir_o           = r_hazir;
    assign cdf_min_o         = r_cdf_min;
    assign toplam_o          = r_toplam;
    assign tasma_o           = r_tasma;
    assign durum_o           = r_durum;

endmodule
`default_nettype wire

// File: tb/tb_histogram_esitleme_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_histogram_esitleme_p
//  Description : Self-checking bench. Instance A uses default parameters;
//                instance B uses COUNT_BIT=3, CLIP_LIMIT=2 for the counter
//                saturation and clipping frames. Expectations follow
//                HE_CLIP_EN when that macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_histogram_esitleme_p;

    localparam int F_DURUM = 0, F_TOPLAM = 1, F_MIN = 2, F_TASMA = 3;
    localparam int F_HAZIR = 4, F_PV = 5, F_PO = 6, F_RDY = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baslat_a = 1'b0, baslat_b = 1'b0;
    logic       hazir_a, hazir_b, tasma_a, tasma_b;
    logic [16:0] cdf_min_a, toplam_a;
    logic [2:0]  cdf_min_b, toplam_b;
    logic [2:0]  durum_a, durum_b;

    int n_pass = 0;
    int n_tot  = 0;
    int hz_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    histogram_esitleme_p_if #(.PIXEL_BIT(8)) bus_a ();
    histogram_esitleme_p_if #(.PIXEL_BIT(8)) bus_b ();

    histogram_esitleme_p u_dut (
        .clk_i(clk), .rst_i(rst), .baslat_i(baslat_a), .bus(bus_a),
        .hazir_o(hazir_a), .cdf_min_o(cdf_min_a), .toplam_o(toplam_a),
        .tasma_o(tasma_a), .durum_o(durum_a)
    );

    histogram_esitleme_p #(.PIXEL_BIT(8), .COUNT_BIT(3), .CLIP_LIMIT(2)) u_small (
        .clk_i(clk), .rst_i(rst), .baslat_i(baslat_b), .bus(bus_b),
        .hazir_o(hazir_b), .cdf_min_o(cdf_min_b), .toplam_o(toplam_b),
        .tasma_o(tasma_b), .durum_o(durum_b)
    );

    always @(negedge clk) begin
        if (hazir_a) hz_cnt[0] = hz_cnt[0] + 1;
        if (hazir_b) hz_cnt[1] = hz_cnt[1] + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_tot);
        $fatal(1);
    end

    // Packed arrays: element 0 is the rightmost entry of each concatenation.
    typedef struct {
        int               sel;
        int               nf;
        logic [4:0][7:0]  fr;
        int               nm;
        logic [3:0][7:0]  mp;
        logic [3:0][7:0]  ex;
        int               ex_min;
        int               ex_top;
    } case_t;

    case_t cases [4];

    function automatic int rd(input int sel, input int f);
        case (f)
            F_DURUM:  return sel ? int'(durum_b)   : int'(durum_a);
            F_TOPLAM: return sel ? int'(toplam_b)  : int'(toplam_a);
            F_MIN:    return sel ? int'(cdf_min_b) : int'(cdf_min_a);
            F_TASMA:  return sel ? int'(tasma_b)   : int'(tasma_a);
            F_HAZIR:  return sel ? int'(hazir_b)   : int'(hazir_a);
            F_PV:     return sel ? int'(bus_b.pixel_valid_o) : int'(bus_a.pixel_valid_o);
            F_PO:     return sel ? int'(bus_b.pixel_o)       : int'(bus_a.pixel_o);
            default:  return sel ? int'(bus_b.pixel_ready_o) : int'(bus_a.pixel_ready_o);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tot = n_tot + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] p, input logic s);
        if (sel == 0) begin
            bus_a.pixel_valid_i = v; bus_a.pixel_i = p; bus_a.son_i = s;
        end else begin
            bus_b.pixel_valid_i = v; bus_b.pixel_i = p; bus_b.son_i = s;
        end
    endtask

    task automatic wait_state(input int sel, input int st, input int budget, input string nm);
        int n = 0;
        while (rd(sel, F_DURUM) != st && n < budget) begin
            step();
            n++;
        end
        chk(nm, rd(sel, F_DURUM), st);
    endtask

    task automatic pulse_start(input int sel);
        if (sel == 0) baslat_a = 1'b1; else baslat_b = 1'b1;
        step();
        baslat_a = 1'b0;
        baslat_b = 1'b0;
    endtask

    task automatic feed_frame(input int k);
        int s = cases[k].sel;
        pulse_start(s);
        chk("start_state", rd(s, F_DURUM), 1);
        chk("start_tasma", rd(s, F_TASMA), 0);
        chk("start_toplam", rd(s, F_TOPLAM), 0);
        chk("start_cdfmin", rd(s, F_MIN), 0);
        wait_state(s, 2, 400, "reach_accum");
        chk("accum_ready", rd(s, F_RDY), 1);
        for (int i = 0; i < cases[k].nf; i++) begin
            drive(s, 1'b1, cases[k].fr[i], (i == cases[k].nf - 1));
            step();
        end
        drive(s, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic run_case(input int k);
        int s  = cases[k].sel;
        int hb = hz_cnt[s];
        feed_frame(k);
        wait_state(s, 5, 20000, "reach_map");
        chk("hazir_on_map_entry", rd(s, F_HAZIR), 1);
        chk("pv_idle_map", rd(s, F_PV), 0);
        chk("cdf_min", rd(s, F_MIN), cases[k].ex_min);
        chk("toplam", rd(s, F_TOPLAM), cases[k].ex_top);
        chk("tasma_clear", rd(s, F_TASMA), 0);
        for (int i = 0; i < cases[k].nm; i++) begin
            drive(s, 1'b1, cases[k].mp[i], (i == cases[k].nm - 1));
            step();
            chk("map_valid", rd(s, F_PV), 1);
            chk("map_pixel", rd(s, F_PO), int'(cases[k].ex[i]));
        end
        drive(s, 1'b0, 8'd0, 1'b0);
        step();
        chk("map_valid_drop", rd(s, F_PV), 0);
        chk("back_to_idle", rd(s, F_DURUM), 0);
        chk("hazir_single_pulse", hz_cnt[s] - hb, 1);
    endtask

    initial begin
        cases[0].sel = 0; cases[0].nf = 4;
        cases[0].fr  = {8'd0, 8'd40, 8'd30, 8'd20, 8'd10};
        cases[0].nm  = 4;
        cases[0].mp  = {8'd40, 8'd30, 8'd20, 8'd10};
        cases[0].ex  = {8'd255, 8'd170, 8'd85, 8'd0};
        cases[0].ex_min = 1; cases[0].ex_top = 4;

        cases[1].sel = 0; cases[1].nf = 4;
        cases[1].fr  = {8'd0, 8'd255, 8'd255, 8'd0, 8'd0};
        cases[1].nm  = 3;
        cases[1].mp  = {8'd0, 8'd255, 8'd100, 8'd0};
        cases[1].ex  = {8'd0, 8'd255, 8'd0, 8'd0};
        cases[1].ex_min = 2; cases[1].ex_top = 4;

        cases[2].sel = 0; cases[2].nf = 4;
        cases[2].fr  = {8'd0, 8'd7, 8'd7, 8'd7, 8'd7};
        cases[2].nm  = 2;
        cases[2].mp  = {8'd0, 8'd0, 8'd3, 8'd7};
        cases[2].ex  = {8'd0, 8'd0, 8'd3, 8'd7};
        cases[2].ex_min = 4; cases[2].ex_top = 4;

        cases[3].sel = 1; cases[3].nf = 5;
        cases[3].fr  = {8'd9, 8'd3, 8'd3, 8'd3, 8'd3};
        cases[3].nm  = 2;
        cases[3].mp  = {8'd0, 8'd0, 8'd9, 8'd3};
        cases[3].ex  = {8'd0, 8'd0, 8'd255, 8'd0};
`ifdef HE_CLIP_EN
        cases[3].ex_min = 2; cases[3].ex_top = 3;
`else
        cases[3].ex_min = 4; cases[3].ex_top = 5;
`endif

        drive(0, 1'b0, 8'd0, 1'b0);
        drive(1, 1'b0, 8'd0, 1'b0);
        repeat (3) step();

        // Reset state
        chk("rst_durum", rd(0, F_DURUM), 0);
        chk("rst_toplam", rd(0, F_TOPLAM), 0);
        chk("rst_cdfmin", rd(0, F_MIN), 0);
        chk("rst_tasma", rd(0, F_TASMA), 0);
        chk("rst_ready", rd(0, F_RDY), 0);
        chk("rst_pv", rd(0, F_PV), 0);
        rst = 1'b0;
        step();

        // Valid outside ACCUM/MAP is ignored
        drive(0, 1'b1, 8'd5, 1'b1);
        step();
        chk("idle_ignore_valid", rd(0, F_PV), 0);
        chk("idle_stays", rd(0, F_DURUM), 0);
        drive(0, 1'b0, 8'd0, 1'b0);

        for (int k = 0; k < 3; k++) run_case(k);

        // Reset in the middle of the LUT phase
        feed_frame(0);
        wait_state(0, 4, 2000, "reach_lut");
        repeat (40) step();
        rst = 1'b1;
        step();
        chk("midlut_durum", rd(0, F_DURUM), 0);
        chk("midlut_toplam", rd(0, F_TOPLAM), 0);
        chk("midlut_cdfmin", rd(0, F_MIN), 0);
        chk("midlut_tasma", rd(0, F_TASMA), 0);
        chk("midlut_hazir", rd(0, F_HAZIR), 0);
        chk("midlut_pv", rd(0, F_PV), 0);
        chk("midlut_po", rd(0, F_PO), 0);
        chk("midlut_ready", rd(0, F_RDY), 0);
        rst = 1'b0;
        step();
        run_case(0);

        // Counter saturation on the 3-bit instance: nine pixels of value 5
        pulse_start(1);
        wait_state(1, 2, 400, "sat_reach_accum");
        for (int i = 0; i < 9; i++) begin
            drive(1, 1'b1, 8'd5, (i == 8));
            step();
        end
        drive(1, 1'b0, 8'd0, 1'b0);
        chk("sat_to_cdf", rd(1, F_DURUM), 3);
        chk("sat_toplam", rd(1, F_TOPLAM), 7);
        chk("sat_tasma", rd(1, F_TASMA), 1);
        chk("sat_bin5", int'(u_small.r_bins[5]), 7);
        wait_state(1, 5, 20000, "sat_reach_map");
        drive(1, 1'b1, 8'd5, 1'b1);
        step();
        chk("sat_map_valid", rd(1, F_PV), 1);
        chk("sat_map_identity", rd(1, F_PO), 5);
        drive(1, 1'b0, 8'd0, 1'b0);
        step();
        chk("sat_tasma_held", rd(1, F_TASMA), 1);
`ifdef HE_CLIP_EN
        chk("sat_toplam_end", rd(1, F_TOPLAM), 2);
`else
        chk("sat_toplam_end", rd(1, F_TOPLAM), 7);
`endif

        // Next frame clears tasma; clip-sensitive expectations
        run_case(3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
